// File: rtl/vec_store_sequencer.sv
// Serialises a multi-lane vector store onto a single-write-port data memory,
// stalling the core during the burst; scalar stores pass straight through.
module vec_store_sequencer #(
  parameter int LANES  = 5,
  parameter int STRIDE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        VecWrite,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [31:0] VecWriteData_0,
  input  logic [31:0] VecWriteData_1,
  input  logic [31:0] VecWriteData_2,
  input  logic [31:0] VecWriteData_3,
  input  logic [31:0] VecWriteData_4,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        Stall,
  output logic        Busy,
  output logic [2:0]  LaneIdx
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [2:0] LAST_LANE = 3'(LANES - 1);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] base_reg, base_next;
  logic        capture;

  logic [31:0] lane_in  [5];
  logic [31:0] lane_buf [5];

  assign lane_in[0] = VecWriteData_0;
  assign lane_in[1] = VecWriteData_1;
  assign lane_in[2] = VecWriteData_2;
  assign lane_in[3] = VecWriteData_3;
  assign lane_in[4] = VecWriteData_4;

  // Lane 0 is written in the accept cycle, so only lanes 1..LANES-1 need storage.
  for (genvar gi = 0; gi < 5; gi++) begin : g_lane
    if (gi >= 1 && gi < LANES) begin : g_buf
      logic [31:0] lane_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          lane_reg <= '0;
        end else if (capture) begin
          lane_reg <= lane_in[gi];
        end
      end
      assign lane_buf[gi] = lane_reg;
    end else begin : g_none
      assign lane_buf[gi] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      base_reg  <= base_next;
    end
  end

  assign Busy = (state_reg == BURST) && !reset;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    base_next  = base_reg;
    capture    = 1'b0;
    MemWE      = 1'b0;
    MemAddr    = '0;
    MemWData   = '0;
    Stall      = 1'b0;
    LaneIdx    = '0;
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          if (VecWrite) begin
            // Vector store wins; a simultaneous scalar store is dropped.
            MemWE     = 1'b1;
            MemAddr   = ALUResult;
            MemWData  = lane_in[0];
            capture   = 1'b1;
            cnt_next  = 3'd1;
            base_next = ALUResult;
            if (LANES > 1) begin
              Stall      = 1'b1;
              state_next = BURST;
            end
          end else begin
            MemWE    = MemWrite;
            MemAddr  = ALUResult;
            MemWData = WriteData;
          end
        end
        BURST: begin
          MemWE    = 1'b1;
          MemAddr  = base_reg + 32'(STRIDE) * 32'(cnt_reg);
          MemWData = lane_buf[cnt_reg];
          LaneIdx  = cnt_reg;
          // Stall drops on the last lane so the PC advances past the vector op.
          if (cnt_reg == LAST_LANE) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            Stall    = 1'b1;
            cnt_next = cnt_reg + 3'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_store_sequencer.sv
// Directed bench for vec_store_sequencer: a 5-lane instance for scalar, burst,
// wrap, conflict, back-to-back and reset cases, plus a 1-lane instance.
module tb_vec_store_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        vec_write, mem_write;
  logic [31:0] alu_result, write_data;
  logic [31:0] vd0, vd1, vd2, vd3, vd4;

  logic        w5_we, w5_stall, w5_busy;
  logic [31:0] w5_addr, w5_data;
  logic [2:0]  w5_idx;
  logic        w1_we, w1_stall, w1_busy;
  logic [31:0] w1_addr, w1_data;
  logic [2:0]  w1_idx;

  int checks = 0;
  int errors = 0;
  int wr_count;
  logic [31:0] lane_val [5];

  always #5 clk = ~clk;

  vec_store_sequencer #(.LANES(5), .STRIDE(4)) dut5 (
    .clk(clk), .reset(reset), .VecWrite(vec_write), .MemWrite(mem_write),
    .ALUResult(alu_result), .WriteData(write_data),
    .VecWriteData_0(vd0), .VecWriteData_1(vd1), .VecWriteData_2(vd2),
    .VecWriteData_3(vd3), .VecWriteData_4(vd4),
    .MemWE(w5_we), .MemAddr(w5_addr), .MemWData(w5_data),
    .Stall(w5_stall), .Busy(w5_busy), .LaneIdx(w5_idx)
  );

  vec_store_sequencer #(.LANES(1), .STRIDE(4)) dut1 (
    .clk(clk), .reset(reset), .VecWrite(vec_write), .MemWrite(mem_write),
    .ALUResult(alu_result), .WriteData(write_data),
    .VecWriteData_0(vd0), .VecWriteData_1(vd1), .VecWriteData_2(vd2),
    .VecWriteData_3(vd3), .VecWriteData_4(vd4),
    .MemWE(w1_we), .MemAddr(w1_addr), .MemWData(w1_data),
    .Stall(w1_stall), .Busy(w1_busy), .LaneIdx(w1_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic stall, input logic busy,
                             input logic [2:0] idx);
    check({tag, ".we"}, 32'(w5_we), 32'(we));
    if (we) begin
      check({tag, ".addr"}, w5_addr, addr);
      check({tag, ".data"}, w5_data, data);
      wr_count++;
    end
    check({tag, ".stall"}, 32'(w5_stall), 32'(stall));
    check({tag, ".busy"}, 32'(w5_busy), 32'(busy));
    check({tag, ".idx"}, 32'(w5_idx), 32'(idx));
    $display("%s we=%0b addr=%h data=%h stall=%0b busy=%0b idx=%0d",
             tag, w5_we, w5_addr, w5_data, w5_stall, w5_busy, w5_idx);
  endtask

  // Called at drive time; returns during the last-lane cycle.
  task automatic run_vec(input string tag, input logic [31:0] base, input logic also_scalar,
                         input logic scramble);
    vec_write  = 1'b1;
    mem_write  = also_scalar;
    alu_result = base;
    write_data = 32'h0000_0BAD;
    vd0 = lane_val[0]; vd1 = lane_val[1]; vd2 = lane_val[2];
    vd3 = lane_val[3]; vd4 = lane_val[4];
    #2;
    check_cycle($sformatf("%s.c0", tag), 1'b1, base, lane_val[0], 1'b1, 1'b0, 3'd0);
    for (int i = 1; i < 5; i++) begin
      step();
      if (scramble) begin
        vec_write  = 1'($urandom);
        mem_write  = 1'($urandom);
        alu_result = $urandom;
        write_data = $urandom;
      end else begin
        vec_write  = 1'b0;
        mem_write  = 1'b0;
        alu_result = 32'hDEAD_0000;
      end
      vd0 = $urandom; vd1 = $urandom; vd2 = $urandom; vd3 = $urandom; vd4 = $urandom;
      #2;
      check_cycle($sformatf("%s.c%0d", tag, i), 1'b1, base + 32'(4 * i), lane_val[i],
                  (i < 4), 1'b1, 3'(i));
    end
  endtask

  initial begin
    reset = 1'b1; vec_write = 1'b1; mem_write = 1'b1;
    alu_result = 32'h1234; write_data = 32'h5678;
    vd0 = 1; vd1 = 2; vd2 = 3; vd3 = 4; vd4 = 5;
    wr_count = 0;
    #2;
    check("rst.addr", w5_addr, 32'h0);
    check("rst.data", w5_data, 32'h0);
    check_cycle("rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
    step();
    step();
    reset = 1'b0;

    // Scalar pass-through
    vec_write = 1'b0; mem_write = 1'b1; alu_result = 32'h40; write_data = 32'hDEAD;
    #2;
    check_cycle("scalar", 1'b1, 32'h40, 32'hDEAD, 1'b0, 1'b0, 3'd0);

    // Plain 5-lane vector store
    step();
    lane_val = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    run_vec("vec", 32'h100, 1'b0, 1'b0);

    // Idle cycle after burst: no write, no stall
    step();
    vec_write = 1'b0; mem_write = 1'b0; alu_result = 32'h0;
    #2;
    check_cycle("idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);

    // Address wrap with scrambled core inputs during the burst
    step();
    lane_val = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
    run_vec("wrap", 32'hFFFF_FFF8, 1'b0, 1'b1);

    // Conflict at accept, then back-to-back vector store
    step();
    wr_count = 0;
    lane_val = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    run_vec("conf", 32'h200, 1'b1, 1'b0);
    step();
    lane_val = '{32'h6, 32'h7, 32'h8, 32'h9, 32'hA};
    run_vec("b2b", 32'h300, 1'b0, 1'b0);
    check("b2b.writes", 32'(wr_count), 32'd10);

    // Reset in cycle 2 of a burst
    step();
    lane_val = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4};
    vec_write = 1'b1; mem_write = 1'b0; alu_result = 32'h400;
    vd0 = lane_val[0]; vd1 = lane_val[1]; vd2 = lane_val[2]; vd3 = lane_val[3]; vd4 = lane_val[4];
    #2;
    check_cycle("rmid.c0", 1'b1, 32'h400, 32'hC0, 1'b1, 1'b0, 3'd0);
    step();
    vec_write = 1'b0; alu_result = 32'h123;
    #2;
    check_cycle("rmid.c1", 1'b1, 32'h404, 32'hC1, 1'b1, 1'b1, 3'd1);
    step();
    reset = 1'b1;
    #2;
    check("rmid.c2.addr", w5_addr, 32'h0);
    check_cycle("rmid.c2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
    step();
    reset = 1'b0;
    #2;
    check_cycle("rmid.c3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
    step();
    mem_write = 1'b1; alu_result = 32'h44; write_data = 32'hBEEF;
    #2;
    check_cycle("rmid.scalar", 1'b1, 32'h44, 32'hBEEF, 1'b0, 1'b0, 3'd0);

    // Single-lane instance
    step();
    mem_write = 1'b0; vec_write = 1'b1; alu_result = 32'h500; vd0 = 32'h77;
    #2;
    check("l1.we", 32'(w1_we), 32'd1);
    check("l1.addr", w1_addr, 32'h500);
    check("l1.data", w1_data, 32'h77);
    check("l1.stall", 32'(w1_stall), 32'd0);
    check("l1.busy", 32'(w1_busy), 32'd0);
    $display("l1.c0 we=%0b addr=%h data=%h stall=%0b busy=%0b", w1_we, w1_addr, w1_data, w1_stall, w1_busy);
    step();
    vec_write = 1'b0;
    #2;
    check("l1.next.we", 32'(w1_we), 32'd0);
    check("l1.next.stall", 32'(w1_stall), 32'd0);
    check("l1.next.busy", 32'(w1_busy), 32'd0);
    $display("l1.c1 we=%0b stall=%0b busy=%0b", w1_we, w1_stall, w1_busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_store_sequencer.md
# vec_store_sequencer

Serialises the five-lane vector store produced by the single-cycle `arm` core onto the single-write-port data memory, and passes ordinary scalar stores straight through. It sits between `arm` and the data memory. It stalls the core for the duration of a vector burst and takes ownership of the memory write port while the burst runs. Lane data and the base address are captured in the accept cycle, so the core may hold or change its outputs afterwards without effect.

## Interface
Parameters:
- `LANES`, default 5: number of lanes written per vector store. Legal range 1..5; lanes numbered `LANES` and above are ignored.
- `STRIDE`, default 4: byte distance between consecutive lane addresses.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `VecWrite`  in  1  core requests a vector store this cycle.
- `MemWrite`  in  1  core requests a scalar store this cycle.
- `ALUResult`  in  32  store address; for a vector store, the base address.
- `WriteData`  in  32  scalar store data.
- `VecWriteData_0` .. `VecWriteData_4`  in  32 each  lane data 0..4.
- `MemWE`  out  1  data-memory write enable.
- `MemAddr`  out  32  data-memory address.
- `MemWData`  out  32  data-memory write data.
- `Stall`  out  1  when high, the core must hold PC and suppress register-file writes.
- `Busy`  out  1  a burst is in progress (state BURST).
- `LaneIdx`  out  3  index of the lane being written this cycle; 0 when not writing a lane.

## Operation
States: IDLE and BURST. Registers:
- lane buffer, lanes 1..`LANES`-1, 32 bits each
- base address, 32 bits
- lane counter `cnt`, 3 bits

IDLE with `VecWrite` = 0:
- Pass-through: `MemWE` = `MemWrite`, `MemAddr` = `ALUResult`, `MemWData` = `WriteData`.
- `Stall` = 0, `LaneIdx` = 0.

IDLE with `VecWrite` = 1 (accept cycle):
- Lane 0 is written combinationally in this cycle: `MemWE` = 1, `MemAddr` = `ALUResult`, `MemWData` = `VecWriteData_0`.
- Lanes 1..`LANES`-1 and `ALUResult` are latched, and `cnt` is set to 1.
- If `LANES` > 1: `Stall` = 1 and the next state is BURST.
- If `LANES` = 1: `Stall` = 0 and the state stays IDLE.
- `VecWrite` has priority over `MemWrite`. A simultaneous scalar store is dropped; this is an illegal decode.

BURST:
- Drive `MemWE` = 1, `MemAddr` = base + `STRIDE`*`cnt` (modulo 2^32, wrap-around allowed), `MemWData` = buffer[`cnt`], `LaneIdx` = `cnt`.
- `Stall` = 1 while `cnt` < `LANES`-1, and 0 when `cnt` = `LANES`-1 (last lane). Dropping `Stall` on the last lane lets the PC advance on that edge, so the vector instruction is not re-issued.
- On the last lane, the next state is IDLE. Otherwise `cnt` increments.
- All core inputs (`VecWrite`, `MemWrite`, `ALUResult`, data) are ignored in BURST.

Reset (`reset` = 1 in a cycle):
- `MemWE` = 0, `Stall` = 0, `Busy` = 0, `LaneIdx` = 0, `MemAddr` = 0, `MemWData` = 0, combinationally forced in that cycle.
- Next state is IDLE with `cnt` = 0 and buffers cleared.
- A reset mid-burst abandons the remaining lanes. Lanes already written stay written.

## Timing
- Scalar store: zero added latency, written on the same edge as in a design without this block.
- Vector store:
  - Takes `LANES` cycles (cycle 0 = accept).
  - Lane i is written at the end of cycle i.
  - The core is stalled for `LANES`-1 cycles in total; `Stall` is high in cycles 0..`LANES`-2.
- `Busy` is registered: high in cycles 1..`LANES`-1.
- `MemWE`, `MemAddr`, `MemWData` and `Stall` are combinational from state and inputs. `LaneIdx` in BURST comes from the registered counter.
- Back-to-back vector stores: the cycle after the last lane is IDLE and may accept a new `VecWrite` immediately. There is no bubble.
- Exactly one memory write per cycle at most; the write port is never double-driven.

## Test plan
- Scalar store: `MemWrite` = 1, `ALUResult` = 0x40, `WriteData` = 0xDEAD -> same cycle `MemWE` = 1, `MemAddr` = 0x40, `MemWData` = 0xDEAD, `Stall` = 0.
- Vector store, `LANES` = 5: `VecWrite` = 1, base 0x100, lanes 0x11..0x55 -> writes 0x100/0x11, 0x104/0x22, 0x108/0x33, 0x10C/0x44, 0x110/0x55 on 5 consecutive cycles; `Stall` high for cycles 0..3 and low in cycle 4; `Busy` high in cycles 1..4.
- Wrap and input isolation: base 0xFFFFFFF8; core inputs toggled randomly during BURST -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8, with the data latched at accept.
- Conflict and back-to-back: `VecWrite` and `MemWrite` both high at accept -> scalar store dropped. Then a second `VecWrite` in the cycle after the last lane -> accepted immediately; 10 writes over 10 cycles.
- Reset mid-burst: `reset` asserted in cycle 2 -> `MemWE` = 0 that cycle, no further writes, IDLE next cycle; a following scalar store passes through normally.
- `LANES` = 1: `VecWrite` -> single write of lane 0, `Stall` never asserted, `Busy` stays 0.
